// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed digit scanner with blanking gaps, frame-synchronous score commit and leading-zero blanking
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] iValue,
  input  logic                    iLoad,
  input  logic                    iLzb,
  output logic [3:0]              oNum,
  output logic [NUM_DIGITS-1:0]   oDigitEn,
  output logic                    oPending,
  output logic                    oFrame
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  typedef enum logic {BLANK, SHOW} state_t;
  state_t state, nState;
  logic [CW-1:0] cnt, nCnt;
  logic [IW-1:0] idx, nIdx;
  logic [NUM_DIGITS-1:0][3:0] display, nDisplay, shadow;
  logic [NUM_DIGITS-1:0] zeroFrom, nEn;
  logic [3:0] nNum;
  logic nFrame, commit, suppress, z;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= BLANK;
      cnt      <= '0;
      idx      <= '0;
      display  <= '0;
      shadow   <= '0;
      oNum     <= '0;
      oDigitEn <= '1;
      oPending <= 1'b0;
      oFrame   <= 1'b0;
    end else begin
      state    <= nState;
      cnt      <= nCnt;
      idx      <= nIdx;
      display  <= nDisplay;
      shadow   <= iLoad ? iValue : shadow;
      oNum     <= nNum;
      oDigitEn <= nEn;
      oPending <= iLoad | (oPending & ~commit);
      oFrame   <= nFrame;
    end
  // zeroFrom[k]: nibbles k..top of the committed value are all zero
  always_comb begin
    zeroFrom = '0;
    z = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      z = z & (display[k] == 4'd0);
      zeroFrom[k] = z;
    end
  end
  assign suppress = iLzb && idx != '0 && zeroFrom[idx];
  always_comb begin
    nState   = state;
    nCnt     = cnt + 1'b1;
    nIdx     = idx;
    nDisplay = display;
    nNum     = oNum;
    nFrame   = 1'b0;
    commit   = 1'b0;
    if (state == BLANK) begin
      nState = cnt == CW'(BLANK_CYCLES - 1) ? SHOW : BLANK;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      nState   = BLANK;
      nCnt     = '0;
      nIdx     = idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
      commit   = nIdx == '0 && oPending;
      nDisplay = commit ? shadow : display;
      nNum     = nDisplay[nIdx];
      nFrame   = commit;
    end
    nEn = (nState == SHOW && !suppress) ? ~(NUM_DIGITS'(1) << idx) : '1;
  end
endmodule
